// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg: definitions shared by the match-3 board-processing stages.
//   N          board side length (rows = columns)
//   CELL_W     bits per cell
//   BOARD_W    bits in a flattened board, cell (r,c) at (r*N+c)*CELL_W
//   SCORE_W    width of the saturating score accumulator
//   COUNT_W    width of a cleared-cell count (0..N*N)
//   CELL_EMPTY / CELL_BLOCK  the two cell codes that never form a match
//   state_t    scan sequencer states of match_eliminate
//   cell_idx() bit offset of cell (r,c) in a flattened board
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int N       = 8;
    localparam int CELL_W  = 3;
    localparam int CELLS   = N * N;
    localparam int BOARD_W = CELLS * CELL_W;
    localparam int LINE_W  = N * CELL_W;
    localparam int SCORE_W = 16;
    localparam int COUNT_W = 7;

    localparam logic [CELL_W-1:0] CELL_EMPTY = 3'd0;
    localparam logic [CELL_W-1:0] CELL_BLOCK = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_CLEAR,
        ST_DONE
    } state_t;

    function automatic int cell_idx(input int r, input int c);
        return (r * N + c) * CELL_W;
    endfunction

endpackage

// File: rtl/line_match.sv
// ---------------------------------------------------------------------------
// line_match: purely combinational run detector for one line of N cells.
//   i_line   N cells packed LSB-first, cell k at i_line[k*CELL_W +: CELL_W]
//   o_marks  bit k set when cell k belongs to a run of >= 3 equal colours
// EMPTY and BLOCK cells never match. A run of length k marks all k cells
// because every 3-cell window inside it marks its own three cells.
// ---------------------------------------------------------------------------
module line_match
    import game_pkg::*;
(
    input  logic [LINE_W-1:0] i_line,
    output logic [N-1:0]      o_marks
);

    logic [CELL_W-1:0] w_a;
    logic [CELL_W-1:0] w_b;
    logic [CELL_W-1:0] w_c;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_marks = '0;
        w_a     = '0;
        w_b     = '0;
        w_c     = '0;
        for (int i = 0; i <= N - 3; i++) begin
            w_a = i_line[i*CELL_W     +: CELL_W];
            w_b = i_line[(i+1)*CELL_W +: CELL_W];
            w_c = i_line[(i+2)*CELL_W +: CELL_W];
            if (w_a != CELL_EMPTY && w_a != CELL_BLOCK && w_a == w_b && w_b == w_c) begin
                o_marks[i +: 3] = 3'b111;
            end
        end
    end

endmodule

// File: rtl/match_eliminate.sv
// ---------------------------------------------------------------------------
// match_eliminate: scans a settled board for horizontal/vertical runs of
// three or more identical colours and clears those cells to EMPTY.
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          scan request, sampled only while idle
//   board          input board, latched when start is accepted
//   clr_score      synchronous clear of score (wins over a same-cycle add)
//   busy           high from the cycle after start is accepted until done
//   done           one-cycle pulse, results valid
//   new_board      board with matched cells zeroed, held until next scan
//   found          at least one cell cleared in the last scan
//   cleared_count  number of distinct cells cleared (0..64)
//   score          saturating running total of cleared cells
// One row per cycle (8), then one column per cycle (8), then CLEAR and DONE:
// 19 cycles per board. A single line_match serves both passes.
// ---------------------------------------------------------------------------
module match_eliminate
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BOARD_W-1:0] board,
    input  logic               clr_score,
    output logic               busy,
    output logic               done,
    output logic [BOARD_W-1:0] new_board,
    output logic               found,
    output logic [COUNT_W-1:0] cleared_count,
    output logic [SCORE_W-1:0] score
);

    state_t             r_state;
    logic [2:0]         r_idx;
    logic [BOARD_W-1:0] r_work;
    logic [CELLS-1:0]   r_mask;

    logic [LINE_W-1:0]  w_line;
    logic [N-1:0]       w_marks;
    logic [CELLS-1:0]   w_mask_next;
    logic [BOARD_W-1:0] w_cleared;
    logic [COUNT_W-1:0] w_count;
    logic [SCORE_W:0]   w_sum;
    logic [SCORE_W-1:0] w_score_sat;

    // Row idx is a contiguous slice; column idx is gathered cell by cell.
    always_comb begin
        w_line = r_work[int'(r_idx)*LINE_W +: LINE_W];
        if (r_state == ST_COL) begin
            for (int r = 0; r < N; r++) begin
                w_line[r*CELL_W +: CELL_W] = r_work[cell_idx(r, int'(r_idx)) +: CELL_W];
            end
        end
    end

    line_match u_line_match (
        .i_line  (w_line),
        .o_marks (w_marks)
    );

    // Marks are OR-ed in, so cells shared by crossing runs count once.
    always_comb begin
        w_mask_next = r_mask;
        for (int k = 0; k < N; k++) begin
            if (r_state == ST_ROW) begin
                w_mask_next[int'(r_idx)*N + k] = r_mask[int'(r_idx)*N + k] | w_marks[k];
            end else if (r_state == ST_COL) begin
                w_mask_next[k*N + int'(r_idx)] = r_mask[k*N + int'(r_idx)] | w_marks[k];
            end
        end
    end

    always_comb begin
        w_cleared = r_work;
        w_count   = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (r_mask[i]) begin
                w_cleared[i*CELL_W +: CELL_W] = CELL_EMPTY;
                w_count = w_count + COUNT_W'(1);
            end
        end
    end

    // One extra bit catches the carry; a carry means the score saturates.
    assign w_sum       = {1'b0, score} + {{(SCORE_W + 1 - COUNT_W){1'b0}}, w_count};
    assign w_score_sat = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            // NOTE: the working board is reset too; it is only a register
            // vector, not a RAM, so the reset costs nothing awkward.
            r_work        <= '0;
            r_mask        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            new_board     <= '0;
            found         <= 1'b0;
            cleared_count <= '0;
            score         <= '0;
        end else begin
            done <= 1'b0;

            if (clr_score) begin
                score <= '0;
            end else if (r_state == ST_CLEAR) begin
                score <= w_score_sat;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work  <= board;
                        r_mask  <= '0;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_ROW;
                    end
                end
                ST_ROW: begin
                    r_mask <= w_mask_next;
                    if (r_idx == 3'd7) begin
                        r_idx   <= '0;
                        r_state <= ST_COL;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                ST_COL: begin
                    r_mask <= w_mask_next;
                    if (r_idx == 3'd7) begin
                        r_idx   <= '0;
                        r_state <= ST_CLEAR;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                ST_CLEAR: begin
                    new_board     <= w_cleared;
                    cleared_count <= w_count;
                    found         <= |r_mask;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_eliminate.sv
// ---------------------------------------------------------------------------
// tb_match_eliminate: directed bench for match_eliminate. Boards and their
// expected results are built by hand from a checkerboard background.
// ---------------------------------------------------------------------------
module tb_match_eliminate;
    import game_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               clr_score = 1'b0;
    logic [BOARD_W-1:0] board = '0;
    logic               busy;
    logic               done;
    logic [BOARD_W-1:0] new_board;
    logic               found;
    logic [COUNT_W-1:0] cleared_count;
    logic [SCORE_W-1:0] score;

    int errors = 0;
    int checks = 0;
    int lat;
    int done_cnt;
    logic busy_e0;

    logic [BOARD_W-1:0] cb, b1, e1, b3, e3, b4, e4, b5, all_ones;

    always #5 clk = ~clk;

    match_eliminate dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .board         (board),
        .clr_score     (clr_score),
        .busy          (busy),
        .done          (done),
        .new_board     (new_board),
        .found         (found),
        .cleared_count (cleared_count),
        .score         (score)
    );

    task automatic check(input string tag, input logic [BOARD_W-1:0] obs, input logic [BOARD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BOARD_W-1:0] put(input logic [BOARD_W-1:0] b, input int r, input int c,
                                               input logic [CELL_W-1:0] v);
        b[cell_idx(r, c) +: CELL_W] = v;
        return b;
    endfunction

    // Start a scan and wait (bounded) for done. clr_at / poke_at name the
    // number of edges after acceptance at which clr_score or a second start
    // (with a different board) is driven for one cycle; -1 disables them.
    task automatic run_scan(input logic [BOARD_W-1:0] b, input int clr_at, input int poke_at,
                            input logic [BOARD_W-1:0] poke_b);
        @(negedge clk);
        board = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 0;
        busy_e0 = busy;
        while (done !== 1'b1 && lat < 40) begin
            clr_score = (lat == clr_at);
            if (lat == poke_at) begin
                start = 1'b1;
                board = poke_b;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        clr_score = 1'b0;
        start     = 1'b0;
    endtask

    task automatic count_dones(input int cycles);
        done_cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
    endtask

    initial begin
        // Background: 1 where r+c is even, 2 elsewhere -- no runs anywhere.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                cb = put(cb, r, c, ((r + c) % 2 == 0) ? 3'd1 : 3'd2);

        b1 = put(put(put(cb, 0, 0, 3'd3), 0, 1, 3'd3), 0, 2, 3'd3);
        e1 = put(put(put(cb, 0, 0, 3'd0), 0, 1, 3'd0), 0, 2, 3'd0);

        b3 = put(put(put(put(put(cb, 3, 2, 3'd4), 3, 3, 3'd4), 3, 4, 3'd4), 4, 3, 3'd4), 5, 3, 3'd4);
        e3 = put(put(put(put(put(cb, 3, 2, 3'd0), 3, 3, 3'd0), 3, 4, 3'd0), 4, 3, 3'd0), 5, 3, 3'd0);

        b4 = cb;
        e4 = cb;
        for (int k = 0; k < N; k++) begin
            b4 = put(b4, 5, k, 3'd5);
            e4 = put(e4, 5, k, 3'd0);
            e4 = put(e4, k, 0, 3'd0);
        end
        for (int k = 0; k < N; k++) b4 = put(b4, k, 0, 3'd6);

        b5 = cb;
        for (int k = 0; k < N; k++) begin
            b5 = put(b5, 2, k, 3'd0);
            b5 = put(b5, 6, k, 3'd7);
        end

        for (int i = 0; i < CELLS; i++) all_ones[i*CELL_W +: CELL_W] = 3'd1;

        // Reset state
        #12;
        check("rst_busy",  BOARD_W'(busy), '0);
        check("rst_done",  BOARD_W'(done), '0);
        check("rst_board", new_board, '0);
        check("rst_found", BOARD_W'(found), '0);
        check("rst_count", BOARD_W'(cleared_count), '0);
        check("rst_score", BOARD_W'(score), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three-in-a-row on row 0
        run_scan(b1, -1, -1, '0);
        check("t1_busy_e0", BOARD_W'(busy_e0), BOARD_W'(1));
        check("t1_latency", BOARD_W'(lat), BOARD_W'(18));
        check("t1_board",   new_board, e1);
        check("t1_count",   BOARD_W'(cleared_count), BOARD_W'(3));
        check("t1_found",   BOARD_W'(found), BOARD_W'(1));
        check("t1_score",   BOARD_W'(score), BOARD_W'(3));
        check("t1_busy_dn", BOARD_W'(busy), '0);
        @(posedge clk);
        #1;
        check("t1_done_pulse", BOARD_W'(done), '0);
        check("t1_hold", new_board, e1);

        // Pure checkerboard: nothing to clear
        run_scan(cb, -1, -1, '0);
        check("t2_latency", BOARD_W'(lat), BOARD_W'(18));
        check("t2_board",   new_board, cb);
        check("t2_count",   BOARD_W'(cleared_count), '0);
        check("t2_found",   BOARD_W'(found), '0);
        check("t2_score",   BOARD_W'(score), BOARD_W'(3));

        // T shape: shared cell counted once
        run_scan(b3, -1, -1, '0);
        check("t3_board", new_board, e3);
        check("t3_count", BOARD_W'(cleared_count), BOARD_W'(5));
        check("t3_score", BOARD_W'(score), BOARD_W'(8));

        // Clear score while idle, then two back-to-back cross scans
        @(negedge clk);
        clr_score = 1'b1;
        @(negedge clk);
        clr_score = 1'b0;
        check("t4_clr", BOARD_W'(score), '0);
        run_scan(b4, -1, -1, '0);
        check("t4a_board", new_board, e4);
        check("t4a_count", BOARD_W'(cleared_count), BOARD_W'(15));
        check("t4a_score", BOARD_W'(score), BOARD_W'(15));
        run_scan(b4, -1, -1, '0);
        check("t4b_latency", BOARD_W'(lat), BOARD_W'(18));
        check("t4b_count",   BOARD_W'(cleared_count), BOARD_W'(15));
        check("t4b_score",   BOARD_W'(score), BOARD_W'(30));

        // EMPTY and BLOCK rows never match; a start plus board change while
        // busy must be ignored
        run_scan(b5, -1, 5, b1);
        check("t5_latency", BOARD_W'(lat), BOARD_W'(18));
        check("t5_board",   new_board, b5);
        check("t5_count",   BOARD_W'(cleared_count), '0);
        check("t5_found",   BOARD_W'(found), '0);
        check("t5_score",   BOARD_W'(score), BOARD_W'(30));
        count_dones(25);
        check("t5_single_done", BOARD_W'(done_cnt), '0);

        // Reset in the middle of a scan
        @(negedge clk);
        board = b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy",  BOARD_W'(busy), '0);
        check("t6_score", BOARD_W'(score), '0);
        check("t6_board", new_board, '0);
        check("t6_count", BOARD_W'(cleared_count), '0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(25);
        check("t6_no_done", BOARD_W'(done_cnt), '0);

        // Saturation: 1023 full clears reach 65472, the next saturates
        for (int s = 0; s < 1023; s++) run_scan(all_ones, -1, -1, '0);
        check("t7_pre_sat", BOARD_W'(score), BOARD_W'(65472));
        check("t7_full_count", BOARD_W'(cleared_count), BOARD_W'(64));
        check("t7_full_board", new_board, '0);
        run_scan(all_ones, -1, -1, '0);
        check("t7_sat", BOARD_W'(score), BOARD_W'(65535));
        run_scan(all_ones, -1, -1, '0);
        check("t7_sat_hold", BOARD_W'(score), BOARD_W'(65535));

        // clr_score coinciding with the CLEAR-cycle add
        run_scan(all_ones, 16, -1, '0);
        check("t8_latency", BOARD_W'(lat), BOARD_W'(18));
        check("t8_clr_prio", BOARD_W'(score), '0);
        check("t8_found", BOARD_W'(found), BOARD_W'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/match_eliminate.md
Name: match_eliminate

Overview:
Upstream neighbour of the board refresh stage in the 8x8 match-3 logic. It takes a settled 192-bit board, finds every horizontal or vertical run of three or more identical colours, and clears those cells to EMPTY. It also reports how many cells were cleared and keeps a running score. The result feeds the gravity/refill stage, which fills the holes it leaves.

Parameters:
N, 8, board side length (rows = columns = N)
CELL_W, 3, bits per cell
SCORE_W, 16, width of the saturating score accumulator

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request scan of board; sampled only in IDLE
board  in  192  input board; cell (r,c) at board[(r*8+c)*3 +: 3], row 0 = top
clr_score  in  1  synchronous clear of score
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; new_board/found/cleared_count valid
new_board  out  192  board with matched cells set to 3'd0, held until the next done
found  out  1  at least one cell was cleared in the last scan
cleared_count  out  7  number of distinct cells cleared, 0..64
score  out  16  accumulated cleared cells, saturating

Behaviour:
- Encoding: 3'd0 = EMPTY; 1..6 = colours; 7 = reserved/blocker. Runs of 0 or 7 never match.
- Reset (asynchronous, rst_n=0): state=IDLE, busy=0, done=0, new_board=0, found=0, cleared_count=0, score=0, mark mask=0, index=0.
- States and transitions:
  - IDLE: when start=1, latch board into the working register, clear the 64-bit mark mask, set idx=0, go to ROW.
  - ROW: each cycle, run row idx through line_match and OR the result into the mark bits for that row. At idx=7, set idx=0 and go to COL.
  - COL: same as ROW for column idx. At idx=7, go to CLEAR.
  - CLEAR: zero every marked cell into new_board. Set cleared_count = popcount(mask) and found = (mask != 0). Update score = min(score + cleared_count, 2^16 - 1). Go to DONE.
  - DONE: done=1 for this cycle only, then return to IDLE.
- Latency: start is sampled at edge E0. busy is high from E0 through the DONE cycle. done is high for the cycle following edge E0+18 (8 row + 8 column + CLEAR + DONE). Throughput is one board per 19 cycles.
- Overlapping runs (L/T/cross shapes) count each cell once; the mask is OR-ed.
- A run of length k >= 3 marks all k cells, including full-length runs of 8.
- start while busy is ignored, with no queueing. Input board is sampled only at E0; later changes have no effect.
- clr_score has priority over the CLEAR-cycle add when both occur in the same cycle: score becomes 0.
- new_board, found and cleared_count change only in the CLEAR cycle. Between scans they hold their last values.
- rst_n asserted mid-scan aborts the scan immediately, and all outputs return to reset values.

Decomposition:
- Shared package (game_pkg): N, CELL_W, BOARD_W=192, CELL_EMPTY=3'd0, CELL_BLOCK=3'd7, and a cell-index helper for (r*N+c)*CELL_W.
- One combinational sub-module, line_match: takes 8 cells (24 bits) and outputs an 8-bit mark mask for runs of 3 or more equal colours in 1..6. It is used for both row and column passes; the column is gathered by a mux on idx.
- The top level holds the FSM, idx counter, working board, mask, popcount, and score.

Test Plan:
- Background checkerboard (cell = 1 if r+c even, else 2) with value 3 at row 0, cols 0-2; pulse start -> done 18 edges later; those 3 cells = 0, all others unchanged; cleared_count=3, found=1, score=3.
- Pure checkerboard -> new_board == board, cleared_count=0, found=0, score unchanged.
- Value 4 at row 3 cols 2-4 and col 3 rows 3-5 (T/L shape) -> 5 cells cleared (shared cell counted once), cleared_count=5.
- Row 5 entirely 5 and column 0 entirely 6 (they intersect at (5,0); set that cell to 6) -> row run cols 1-7 = 7 cells plus column 8 cells = 15 cleared; score accumulates across two back-to-back scans to 30.
- Row of all 0 and a row of all 7 -> nothing cleared, cleared_count=0; also pulse start at cycle 5 of a busy scan -> ignored, single done.
- Drop rst_n at E0+7 -> busy=0, score=0, no done; score preset near 65535 via repeated scans -> saturates at 65535; clr_score with done -> 0.
